// File: rtl/frame_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_seq_pkg
// Description : Shared types and constants for the frame sequencer: FSM state
//               encoding, default VGA geometry and job-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } seq_state_t;

  // Default 640x480 VGA geometry
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_V_DISPLAY = 480;

  // Width of the job index register; never narrower than one bit
  function automatic int job_idx_width(input int n_jobs);
    return (n_jobs > 1) ? $clog2(n_jobs) : 1;
  endfunction

endpackage : frame_seq_pkg
`default_nettype wire

// File: rtl/frame_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : frame_seq_watchdog
// Description : Per-job timeout counter. Cleared while a job is being started,
//               counts each cycle the sequencer waits, and flags expiry on the
//               TIMEOUT-th waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_seq_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Wait-cycle counter; saturates so it can never wrap back under the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && (cnt != CNT_W'(TIMEOUT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds (waiting cycles - 1), so expiry lands on the TIMEOUT-th one
  assign expired = count && (cnt >= CNT_W'(TIMEOUT - 1));

endmodule : frame_seq_watchdog
`default_nettype wire

// File: rtl/frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : frame_sequencer
// Description : Detects vertical-blank entry on the VGA raster and hands the
//               update window to N_JOBS game-logic blocks in fixed order using
//               a one-hot start pulse / done handshake. Flags an overrun when
//               active display begins while a sequence is still running.
//               Optional watchdog: define FRAME_SEQ_WATCHDOG_EN to force a
//               stuck job to be treated as done after TIMEOUT wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int N_JOBS    = 4,
  parameter int FRAME_DIV = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hpos,
  input  logic [9:0]        vpos,
  input  logic              run_en,
  input  logic [N_JOBS-1:0] job_done,
  input  logic              clr_overrun,
  output logic [N_JOBS-1:0] job_start,
  output logic              busy,
  output logic              frame_tick,
  output logic [7:0]        frame_cnt,
  output logic              overrun,
  output logic              timeout
);

  localparam int IDX_W = job_idx_width(N_JOBS);
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_JOBS - 1);

  // Reject configurations outside the supported ranges at elaboration
  generate
    if ((N_JOBS < 2) || (N_JOBS > 8) || (FRAME_DIV < 1) || (FRAME_DIV > 16) ||
        (TIMEOUT < 1) || (H_DISPLAY < 1) || (V_DISPLAY < 1)) begin : g_param_check
      $error("frame_sequencer: parameter out of supported range");
    end
  endgenerate

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             vb_hit;
  logic             frame_start;
  logic             eligible;
  logic             job_advance;
  logic             seq_done;
  logic             wd_expired;

  assign vb_hit      = (vpos == 10'(V_DISPLAY)) && (hpos == 10'd0);
  assign frame_start = (vpos == 10'd0) && (hpos == 10'd0);
  assign eligible    = (div_cnt == '0);

  // Only the bit of the job currently being waited on matters
  assign job_advance = job_done[idx] || wd_expired;

  // Next-state logic: launch on an eligible vblank, step through jobs in order
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    seq_done  = 1'b0;
    case (state)
      IDLE: begin
        if (vb_hit && eligible && run_en) begin
          idx_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (job_advance) begin
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            seq_done  = 1'b1;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = START;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and job index registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Registered outputs derived from the upcoming state so the start pulse
  // coincides with the START cycle and busy/frame_tick track the transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job_start  <= '0;
      busy       <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      job_start  <= (state_nxt == START) ? (N_JOBS'(1) << idx_nxt) : '0;
      busy       <= (state_nxt != IDLE);
      frame_tick <= seq_done;
      if (seq_done) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Frame divider: advances on every vblank, busy or not
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (vb_hit) begin
      div_cnt <= (div_cnt == DIV_W'(FRAME_DIV - 1)) ? '0 : div_cnt + 1'b1;
    end
  end

  // Sticky overrun; a new overrun in the same cycle beats the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (frame_start && (state != IDLE)) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

`ifdef FRAME_SEQ_WATCHDOG_EN
  frame_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == START),
    .count   (state == WAIT),
    .expired (wd_expired)
  );

  // Sticky timeout: set only when expiry, not a real done, ends the wait
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else if ((state == WAIT) && wd_expired && !job_done[idx]) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_expired = 1'b0;
  assign timeout    = 1'b0;
`endif

endmodule : frame_sequencer
`default_nettype wire
